// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: state encoding and the
// memory read/write polarity also used by the CPU controller.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_CPU     = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_GRANT   = 3'd2,
    ST_ACCESS  = 3'd3,
    ST_RESP    = 3'd4,
    ST_HOLDOFF = 3'd5
  } arb_state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  function automatic logic rw_from_we(input logic we);
    return we ? RW_WRITE : RW_READ;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the arbiter, CPU controller, front-panel loader and memory.
interface mem_arbiter_if;

  logic       usr_pause;
  logic       cpu_paused;
  logic       cpu_pause;
  logic       cpu_en;
  logic       cpu_rw;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;

  logic       ld_req;
  logic       ld_we;
  logic [7:0] ld_addr;
  logic [7:0] ld_wdata;
  logic       ld_ack;
  logic       ld_err;
  logic [7:0] ld_rdata;

  logic       mem_en;
  logic       mem_rw;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  logic       owner;

  modport arb (
    input  usr_pause, cpu_paused, cpu_en, cpu_rw, cpu_addr, cpu_wdata,
    input  ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
    output cpu_pause, ld_ack, ld_err, ld_rdata,
    output mem_en, mem_rw, mem_addr, mem_wdata, owner
  );

  modport env (
    output usr_pause, cpu_paused, cpu_en, cpu_rw, cpu_addr, cpu_wdata,
    output ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
    input  cpu_pause, ld_ack, ld_err, ld_rdata,
    input  mem_en, mem_rw, mem_addr, mem_wdata, owner
  );

endinterface

// File: rtl/mem_arbiter.sv
// Steals the shared memory from the CPU at an instruction boundary to serve
// front-panel loader accesses one at a time, then hands the bus back.
//
// state   | meaning
// CPU     | CPU owns memory, waiting for a loader request
// DRAIN   | pause requested, memory still follows CPU until cpu_paused
// GRANT   | loader owns the idle bus, waiting for / latching a request
// ACCESS  | single memory cycle driven from the latched request
// RESP    | read data captured and acknowledged
// HOLDOFF | bus returned, CPU guaranteed MIN_CPU cycles before next steal
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int MIN_CPU = 8
) (
  input  logic       clk,
  input  logic       rst,
  mem_arbiter_if.arb bus
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int HOLD_W = (MIN_CPU > 1) ? $clog2(MIN_CPU) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MIN_CPU - 1);

  arb_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              lat_we_q, lat_we_d;
  logic [7:0]        lat_addr_q, lat_addr_d;
  logic [7:0]        lat_wdata_q, lat_wdata_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [7:0]        rdata_q, rdata_d;

  logic              cpu_pause_c;
  logic              owner_c;
  logic              mem_en_c;
  logic              mem_rw_c;
  logic [7:0]        mem_addr_c;
  logic [7:0]        mem_wdata_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_CPU;
      wait_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      lat_we_q    <= lat_we_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    lat_we_d    = lat_we_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    rdata_d     = rdata_q;

    cpu_pause_c = bus.usr_pause;
    owner_c     = 1'b0;
    mem_en_c    = bus.cpu_en;
    mem_rw_c    = bus.cpu_rw;
    mem_addr_c  = bus.cpu_addr;
    mem_wdata_c = bus.cpu_wdata;

    unique case (state_q)
      ST_CPU: begin
        if (bus.ld_req && (hold_cnt_q == '0)) begin
          state_d    = ST_DRAIN;
          wait_cnt_d = '0;
        end
      end

      ST_DRAIN: begin
        cpu_pause_c = 1'b1;
        // An acknowledge arriving on the last wait cycle still wins over the timeout.
        if (bus.cpu_paused) begin
          state_d = ST_GRANT;
        end else if (wait_cnt_q == WAIT_LAST) begin
          err_d      = 1'b1;
          state_d    = ST_HOLDOFF;
          hold_cnt_d = HOLD_LOAD;
        end else if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      ST_GRANT: begin
        cpu_pause_c = 1'b1;
        owner_c     = 1'b1;
        mem_en_c    = 1'b0;
        mem_rw_c    = RW_READ;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        if (bus.ld_req) begin
          lat_we_d    = bus.ld_we;
          lat_addr_d  = bus.ld_addr;
          lat_wdata_d = bus.ld_wdata;
          state_d     = ST_ACCESS;
        end else begin
          state_d    = ST_HOLDOFF;
          hold_cnt_d = HOLD_LOAD;
        end
      end

      ST_ACCESS: begin
        cpu_pause_c = 1'b1;
        owner_c     = 1'b1;
        mem_en_c    = 1'b1;
        mem_rw_c    = rw_from_we(lat_we_q);
        mem_addr_c  = lat_addr_q;
        mem_wdata_c = lat_wdata_q;
        if (lat_we_q) begin
          ack_d   = 1'b1;
          state_d = ST_GRANT;
        end else begin
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        cpu_pause_c = 1'b1;
        owner_c     = 1'b1;
        mem_en_c    = 1'b0;
        mem_rw_c    = RW_READ;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        rdata_d     = bus.mem_rdata;
        ack_d       = 1'b1;
        state_d     = ST_GRANT;
      end

      ST_HOLDOFF: begin
        if (hold_cnt_q == '0) begin
          state_d = ST_CPU;
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_CPU;
      end
    endcase
  end

  assign bus.cpu_pause = cpu_pause_c;
  assign bus.owner     = owner_c;
  assign bus.mem_en    = mem_en_c;
  assign bus.mem_rw    = mem_rw_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.ld_ack    = ack_q;
  assign bus.ld_err    = err_q;
  assign bus.ld_rdata  = rdata_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single 8-bit instruction/data memory between the CPU controller and a front-panel loader port (program load and examine). Steals the bus by pausing the CPU at an instruction boundary, serves loader accesses one at a time, then returns the bus. Sits between the CPU controller/datapath, the memory, and the front-panel logic in the top level.

## Interface
- `TIMEOUT`, default 64: cycles to wait for `cpu_paused` before aborting a grant.
- `MIN_CPU`, default 8: CPU-owned cycles guaranteed after every release.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `usr_pause`  in  1  front-panel pause switch.
- `cpu_paused`  in  1  high while the CPU controller sits in its pause state.
- `cpu_pause`  out  1  pause request to the CPU controller.
- `cpu_en`, `cpu_rw`  in  1 each  CPU memory enable and read/write (1 = read).
- `cpu_addr`, `cpu_wdata`  in  8 each  CPU address and write data.
- `ld_req`  in  1  loader access request, level.
- `ld_we`  in  1  loader write (1) or read (0).
- `ld_addr`, `ld_wdata`  in  8 each  loader address and write data.
- `ld_ack`  out  1  one-cycle completion pulse.
- `ld_err`  out  1  one-cycle pulse: grant aborted on timeout.
- `ld_rdata`  out  8  loader read data, held until the next ack.
- `mem_en`, `mem_rw`  out  1 each  memory enable and read/write (1 = read).
- `mem_addr`, `mem_wdata`  out  8 each  memory address and write data.
- `mem_rdata`  in  8  memory read data, valid the cycle after a read enable.
- `owner`  out  1  0 = CPU, 1 = loader (debug LED).

## Operation
- States: CPU, DRAIN, GRANT, ACCESS, RESP, HOLDOFF.
- CPU: memory outputs follow the `cpu_*` inputs combinationally. `cpu_pause` = `usr_pause`. If `ld_req` is high and the holdoff counter is 0, go to DRAIN.
- DRAIN: `cpu_pause`=1 and the wait counter counts up. The memory still follows the CPU until pause is acknowledged.
  - `cpu_paused`=1: go to GRANT.
  - Counter reaches `TIMEOUT`-1: pulse `ld_err` and go to HOLDOFF.
- GRANT: `cpu_pause`=1, `owner`=1, memory outputs idle (`mem_en`=0, `mem_rw`=1).
  - `ld_req`=1: latch `ld_we`, `ld_addr` and `ld_wdata`, then go to ACCESS.
  - `ld_req`=0: go to HOLDOFF and release the bus.
- ACCESS: one cycle. `mem_en`=1, `mem_rw`=!we, and the latched address and data are driven.
  - Write: pulse `ld_ack` and go to GRANT.
  - Read: go to RESP.
- RESP: capture `mem_rdata` into `ld_rdata`, pulse `ld_ack`, go to GRANT.
- HOLDOFF: `owner`=0, `cpu_pause` = `usr_pause`, memory follows the CPU. Counter loads `MIN_CPU`-1 on entry and counts down. Go to CPU when it reaches 0.
- Loader protocol: after `ld_ack`, the loader drops `ld_req` for at least one cycle or presents a new request. A request held high continuously is served again from GRANT.
- `usr_pause` never forces a grant. It only ORs into `cpu_pause`.

## Timing
- Reset values: state CPU, `cpu_pause`=0, `ld_ack`=0, `ld_err`=0, `ld_rdata`=0, `owner`=0, counters 0. Memory outputs follow the CPU inputs.
- Grant latency: `ld_req` rising in CPU → DRAIN on the next edge. `owner`=1 is first seen the edge after `cpu_paused` is sampled high.
- Access latency from GRANT with `ld_req` high: write ack is 2 cycles after the GRANT cycle, read ack is 3 cycles.
- Only ACCESS drives `mem_en` from the loader. There is never more than one memory enable per cycle.
- `cpu_paused` falling while in GRANT, ACCESS or RESP is a protocol violation. The arbiter ignores it and keeps ownership.
- `ld_req` falling during ACCESS or RESP: the access completes and the ack is still pulsed.
- Simultaneous timeout and `cpu_paused` in DRAIN: `cpu_paused` wins, so GRANT and no error.
- Reset asserted mid-access: the memory enable drops immediately (asynchronously) and the in-flight access is lost without an ack.
- Counters wrap-protected: the wait counter saturates and the holdoff counter stops at 0.

## Structure
- Shared package: state encoding constants and the read/write polarity constant (1 = read, shared with the CPU controller).
- One flat module. No sub-module is needed, and both counters stay inline.

## Test plan
- CPU-only traffic with `ld_req`=0: the memory mirrors the `cpu_*` inputs every cycle, and `cpu_pause` tracks `usr_pause`.
- Loader write 0x5A to 0x10 while the CPU is running, with `cpu_paused` rising 5 cycles after pause:
  - `ld_ack` arrives 2 cycles after GRANT.
  - Memory sees `mem_en`=1, `mem_rw`=0, addr 0x10, data 0x5A.
  - The bus returns to the CPU after `MIN_CPU` holdoff cycles.
- Loader read of 0x10 with memory returning 0x5A: `ld_rdata`=0x5A at the `ld_ack` pulse, and the value holds afterwards.
- `cpu_paused` held low: `ld_err` pulses at cycle `TIMEOUT`, no `mem_en` is issued by the loader, and a retry is blocked for `MIN_CPU` cycles.
- Three back-to-back requests with `ld_req` held high: three acks, one pause episode, `owner` stays 1 throughout.
- `rst` asserted during ACCESS: `mem_en` drops within the cycle, then state CPU, `owner`=0 and no ack.
